// File: rtl/arb_req_stage.sv
// Request front-end for a 4-way round-robin arbiter: per-channel FIFOs, req generation,
// and a registered output slot. Define ARB_REQ_STAGE_GNT_CHECK_EN to enable the sticky gnt_err check.
module arb_req_stage #(
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      in_valid,
  input  logic [4*DW-1:0] in_data,
  output logic [3:0]      in_ready,
  output logic [3:0]      req,
  input  logic [3:0]      gnt,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [1:0]      out_src,
  input  logic            out_ready,
  output logic            gnt_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DW-1:0] mem  [4][DEPTH];
  logic [PW-1:0] wptr [4];
  logic [PW-1:0] rptr [4];
  logic [CW-1:0] cnt  [4];

  logic          slot_free;
  logic          gnt_onehot;
  logic [3:0]    push;
  logic [3:0]    pop;
  logic          any_pop;
  logic [1:0]    pop_idx;
  logic [DW-1:0] head;

  assign slot_free  = !out_valid || out_ready;
  assign gnt_onehot = (gnt != 4'b0000) && ((gnt & (gnt - 4'd1)) == 4'b0000);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    in_ready = '0;
    req      = '0;
    push     = '0;
    pop      = '0;
    pop_idx  = '0;
    for (int i = 0; i < 4; i++) begin
      in_ready[i] = !rst && (cnt[i] != FULL);
      req[i]      = !rst && (cnt[i] != '0) && slot_free;
      push[i]     = in_valid[i] && in_ready[i];
      pop[i]      = gnt[i] && req[i] && gnt_onehot;
      if (pop[i]) pop_idx = 2'(i);
    end
    any_pop = |pop;
    head    = mem[pop_idx][rptr[pop_idx]];
  end

  // NOTE: FIFO storage carries no reset; the pointers and counts alone define which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) mem[i][wptr[i]] <= in_data[i*DW +: DW];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) wptr[i] <= wptr[i] + 1'b1;
        if (pop[i])  rptr[i] <= rptr[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + 1'b1;
          2'b01:   cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
      // A pop in the same cycle as a drain replaces the slot, keeping out_valid high.
      if (any_pop) begin
        out_valid <= 1'b1;
        out_data  <= head;
        out_src   <= pop_idx;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef ARB_REQ_STAGE_GNT_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((gnt != 4'b0000) && (!gnt_onehot || ((gnt & ~req) != 4'b0000))) begin
      err_q <= 1'b1;
    end
  end
  assign gnt_err = err_q;
`else
  assign gnt_err = 1'b0;
`endif

endmodule

// File: tb/tb_arb_req_stage.sv
// Directed self-checking bench for arb_req_stage; a small round-robin model drives gnt
// where a real arbiter would.
module tb_arb_req_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic        out_ready;
  logic        gnt_err;

  int n_cmp = 0;
  int n_err = 0;

`ifdef ARB_REQ_STAGE_GNT_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  arb_req_stage #(.DW(8), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .req       (req),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .gnt_err   (gnt_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin grant model: highest priority goes to the channel after the last one granted.
  function automatic logic [3:0] rr(input logic [3:0] r, input logic [1:0] last);
    logic [3:0] g;
    logic [1:0] idx;
    g = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (r[idx] && g == '0) g[idx] = 1'b1;
    end
    return g;
  endfunction

  initial begin
    logic [1:0] last;
    logic [7:0] exp_seq [8];
    int         src_cnt [4];

    rst = 1'b1; in_valid = '0; in_data = '0; gnt = '0; out_ready = 1'b1;
    tick; tick;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_src",   32'(out_src),   32'd0);
    check("rst_in_ready",  32'(in_ready),  32'h0);
    check("rst_req",       32'(req),       32'h0);
    check("rst_gnt_err",   32'(gnt_err),   32'd0);
    rst = 1'b0; #1;
    check("post_rst_in_ready", 32'(in_ready), 32'hF);
    check("post_rst_req",      32'(req),      32'h0);

    // Single transaction on channel 2.
    in_valid = 4'b0100; in_data[16 +: 8] = 8'hA5;
    tick;
    in_valid = '0;
    check("t1_req", 32'(req), 32'h4);
    gnt = 4'b0100;
    tick;
    gnt = '0;
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_out_data",  32'(out_data),  32'hA5);
    check("t1_out_src",   32'(out_src),   32'd2);
    check("t1_req_after", 32'(req),       32'h0);
    tick;
    check("t1_drained", 32'(out_valid), 32'd0);

    // Fill channel 0, third value waits for a pop.
    in_valid = 4'b0001; in_data[0 +: 8] = 8'h01;
    tick;
    in_data[0 +: 8] = 8'h02;
    tick;
    in_data[0 +: 8] = 8'h03;
    check("t2_full_ready", 32'(in_ready[0]), 32'd0);
    tick;
    check("t2_still_full", 32'(in_ready[0]), 32'd0);
    check("t2_req",        32'(req),         32'h1);
    gnt = 4'b0001;
    tick;
    check("t2_out0",       32'(out_data),    32'h01);
    check("t2_ready_open", 32'(in_ready[0]), 32'd1);
    tick;
    in_valid = '0;
    check("t2_out1", 32'(out_data), 32'h02);
    check("t2_req1", 32'(req),      32'h1);
    tick;
    gnt = '0;
    check("t2_out2",   32'(out_data),  32'h03);
    check("t2_valid2", 32'(out_valid), 32'd1);
    check("t2_empty",  32'(req),       32'h0);
    tick;

    // Output stall on channel 1.
    in_valid = 4'b0010; in_data[8 +: 8] = 8'h11;
    tick;
    in_data[8 +: 8] = 8'h12;
    tick;
    in_valid = '0;
    gnt = 4'b0010;
    tick;
    gnt = '0;
    out_ready = 1'b0; #1;
    for (int k = 0; k < 5; k++) begin
      check("t3_stall_req",   32'(req),       32'h0);
      check("t3_stall_valid", 32'(out_valid), 32'd1);
      check("t3_stall_data",  32'(out_data),  32'h11);
      check("t3_stall_src",   32'(out_src),   32'd1);
      tick;
    end
    out_ready = 1'b1; #1;
    check("t3_req_resume", 32'(req), 32'h2);
    gnt = 4'b0010;
    tick;
    gnt = '0;
    check("t3_cont_valid", 32'(out_valid), 32'd1);
    check("t3_next_data",  32'(out_data),  32'h12);
    tick;
    check("t3_drained", 32'(out_valid), 32'd0);

    // Multi-bit grant: no pop, error flag follows build option.
    in_valid = 4'b0011; in_data[0 +: 8] = 8'h21; in_data[8 +: 8] = 8'h31;
    tick;
    in_valid = '0;
    check("t4_req", 32'(req), 32'h3);
    gnt = 4'b0011;
    tick;
    gnt = '0;
    check("t4_no_pop",  32'(out_valid), 32'd0);
    check("t4_req_kept",32'(req),       32'h3);
    check("t4_gnt_err", 32'(gnt_err),   32'(EXP_ERR));
    rst = 1'b1;
    tick;
    rst = 1'b0; #1;
    check("t4_err_clr", 32'(gnt_err), 32'd0);
    check("t4_req_clr", 32'(req),     32'h0);

    // All channels two deep, round-robin drain at full rate.
    in_valid = 4'b1111; in_data = 32'h70605040;
    tick;
    in_data = 32'h71615141;
    tick;
    in_valid = '0;
    check("t5_all_full", 32'(in_ready), 32'h0);
    exp_seq = '{8'h40, 8'h50, 8'h60, 8'h70, 8'h41, 8'h51, 8'h61, 8'h71};
    last = 2'd3;
    for (int k = 0; k < 4; k++) src_cnt[k] = 0;
    for (int k = 0; k < 8; k++) begin
      gnt = rr(req, last);
      for (int j = 0; j < 4; j++) if (gnt[j]) last = 2'(j);
      tick;
      gnt = '0;
      check("t5_valid", 32'(out_valid), 32'd1);
      check("t5_data",  32'(out_data),  32'(exp_seq[k]));
      src_cnt[out_src]++;
    end
    for (int k = 0; k < 4; k++) check("t5_src_count", 32'(src_cnt[k]), 32'd2);
    check("t5_in_ready_end", 32'(in_ready), 32'hF);
    check("t5_req_end",      32'(req),      32'h0);
    tick;
    check("t5_drained", 32'(out_valid), 32'd0);

    // Reset while entries are buffered and the slot is full.
    in_valid = 4'b1101; in_data = 32'h80900000 | 32'h000000A0;
    tick;
    in_valid = 4'b1000; in_data[24 +: 8] = 8'h81;
    tick;
    in_valid = '0;
    gnt = 4'b0100;
    tick;
    gnt = '0;
    check("t6_pre_valid", 32'(out_valid), 32'd1);
    check("t6_pre_data",  32'(out_data),  32'h90);
    check("t6_pre_req",   32'(req),       32'h9);
    rst = 1'b1;
    tick;
    check("t6_rst_valid",    32'(out_valid), 32'd0);
    check("t6_rst_data",     32'(out_data),  32'd0);
    check("t6_rst_req",      32'(req),       32'h0);
    check("t6_rst_in_ready", 32'(in_ready),  32'h0);
    rst = 1'b0; #1;
    check("t6_ready_back", 32'(in_ready), 32'hF);
    for (int k = 0; k < 3; k++) begin
      check("t6_no_stale_req",   32'(req),       32'h0);
      check("t6_no_stale_valid", 32'(out_valid), 32'd0);
      tick;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
